pc_fetch_ctrl: RTL and testbench

Fetch sequencer that owns the program counter and drives the single-outstanding instruction fetch port. It chooses each next PC: sequential +4, branch redirect or trap redirect. It issues one fetch request at a time to instruction memory and discards responses made stale by a redirect. It sits between the execute/CSR redirect sources and decode, and delivers one instruction with its PC per accepted fetch.

---
 rtl/pc_fetch_if.sv | 20 ++
 rtl/pc_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Instruction fetch port between the fetch sequencer (master) and
// instruction memory (slave). Single outstanding request; the response
// is a one-cycle pulse per accepted request.
interface pc_fetch_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_ready, iresp_valid, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_ready, iresp_valid, iresp_data
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC, issues one fetch at a time, drops responses
// made stale by a redirect, and hands instruction+PC to decode.
// Optional feature macro: PC_FETCH_TRAP_EN adds a trap redirect port that
// takes priority over the branch redirect.
module pc_fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [63:0] br_target_i,
`ifdef PC_FETCH_TRAP_EN
  input  logic        trap_valid_i,
  input  logic [63:0] trap_target_i,
`endif
  pc_fetch_if.master  ifc,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic [63:0] inst_pc_o,
  output logic [63:0] pc_out_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        ireq_valid_q, ireq_valid_d;
  logic [63:0] ireq_addr_q, ireq_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [63:0] inst_pc_q, inst_pc_d;

  logic        redir;
  logic [63:0] redir_tgt;

  // Redirect select: trap beats branch when both fire in the same cycle.
`ifdef PC_FETCH_TRAP_EN
  assign redir     = trap_valid_i | br_valid_i;
  assign redir_tgt = trap_valid_i ? trap_target_i : br_target_i;
`else
  assign redir     = br_valid_i;
  assign redir_tgt = br_target_i;
`endif

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    ireq_valid_d = ireq_valid_q;
    ireq_addr_d  = ireq_addr_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;

    // Decode consumes the instruction when not stalled.
    if (inst_valid_q && !stall_i) inst_valid_d = 1'b0;

    // A redirect always retargets the PC and kills the pending instruction.
    if (redir) begin
      pc_d         = redir_tgt;
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!redir && !stall_i) begin
          state_d      = REQ;
          ireq_valid_d = 1'b1;
          ireq_addr_d  = pc_q;
        end
      end
      REQ: begin
        // Stall is ignored here: the request stays up until accepted or withdrawn.
        if (ifc.ireq_ready) begin
          ireq_valid_d = 1'b0;
          if (redir) begin
            state_d = FLUSH;
          end else begin
            req_pc_d = ireq_addr_q;
            pc_d     = ireq_addr_q + 64'(INST_BYTES);
            state_d  = WAIT;
          end
        end else if (redir) begin
          ireq_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      WAIT: begin
        if (ifc.iresp_valid) begin
          state_d = IDLE;
          if (!redir) begin
            inst_valid_d = 1'b1;
            inst_data_d  = ifc.iresp_data;
            inst_pc_d    = req_pc_q;
          end
        end else if (redir) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The accepted request's response is stale; swallow it.
        if (ifc.iresp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 64'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign ifc.ireq_valid = ireq_valid_q;
  assign ifc.ireq_addr  = ireq_addr_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_data_o    = inst_data_q;
  assign inst_pc_o      = inst_pc_q;
  assign pc_out_o       = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, memory backpressure,
// stall hold, stale-response flush, redirect priority, PC wrap, async reset.
module tb_pc_fetch_ctrl;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic [63:0] br_target;
  logic        trap_valid;
  logic [63:0] trap_target;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic [63:0] pc_out;

  int errors = 0;
  int checks = 0;

  pc_fetch_if bus();

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .br_valid_i   (br_valid),
    .br_target_i  (br_target),
`ifdef PC_FETCH_TRAP_EN
    .trap_valid_i (trap_valid),
    .trap_target_i(trap_target),
`endif
    .ifc          (bus.master),
    .inst_valid_o (inst_valid),
    .inst_data_o  (inst_data),
    .inst_pc_o    (inst_pc),
    .pc_out_o     (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ at addr: handshake, one-cycle response, instruction delivered.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data,
                          input logic [63:0] next_pc);
    chk("req_valid", {63'h0, bus.ireq_valid}, 64'h1);
    chk("req_addr", bus.ireq_addr, addr);
    bus.ireq_ready = 1'b1;
    tick();
    bus.ireq_ready = 1'b0;
    chk("req_drop", {63'h0, bus.ireq_valid}, 64'h0);
    chk("pc_after_hs", pc_out, next_pc);
    bus.iresp_valid = 1'b1;
    bus.iresp_data  = data;
    tick();
    bus.iresp_valid = 1'b0;
    chk("inst_valid", {63'h0, inst_valid}, 64'h1);
    chk("inst_data", {32'h0, inst_data}, {32'h0, data});
    chk("inst_pc", inst_pc, addr);
  endtask

  logic [63:0] exp_tgt;

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    trap_valid = 1'b0; trap_target = '0;
    bus.ireq_ready = 1'b0; bus.iresp_valid = 1'b0; bus.iresp_data = '0;
`ifdef PC_FETCH_TRAP_EN
    exp_tgt = 64'h0000_0000_8000_0100;
`else
    exp_tgt = 64'h0000_0000_8000_2000;
`endif

    // Reset state
    tick(); tick();
    chk("rst_req_valid", {63'h0, bus.ireq_valid}, 64'h0);
    chk("rst_req_addr", bus.ireq_addr, RPC);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst_data", {32'h0, inst_data}, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_pc", pc_out, RPC);
    rst_n = 1'b1;

    // First request one edge after release; memory not ready for 3 cycles
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {63'h0, bus.ireq_valid}, 64'h1);
      chk("bp_addr", bus.ireq_addr, RPC);
      chk("bp_pc", pc_out, RPC);
      tick();
    end
    do_fetch(RPC, 32'h0000_0013, 64'h8000_0004);
    tick();
    chk("seq_inst_clr", {63'h0, inst_valid}, 64'h0);
    do_fetch(64'h8000_0004, 32'h0010_0093, 64'h8000_0008);
    tick();
    do_fetch(64'h8000_0008, 32'h0020_0113, 64'h8000_000C);

    // Stall holds instruction and blocks new requests
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_iv", {63'h0, inst_valid}, 64'h1);
      chk("stall_data", {32'h0, inst_data}, 64'h0020_0113);
      chk("stall_pc", inst_pc, 64'h8000_0008);
      chk("stall_noreq", {63'h0, bus.ireq_valid}, 64'h0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_iv", {63'h0, inst_valid}, 64'h0);
    chk("unstall_req", {63'h0, bus.ireq_valid}, 64'h1);
    chk("unstall_addr", bus.ireq_addr, 64'h8000_000C);

    // Branch while WAIT: stale response dropped, refetch at target
    bus.ireq_ready = 1'b1;
    tick();
    bus.ireq_ready = 1'b0;
    br_valid = 1'b1; br_target = 64'h8000_1000;
    tick();
    br_valid = 1'b0;
    chk("br_pc", pc_out, 64'h8000_1000);
    tick();
    bus.iresp_valid = 1'b1; bus.iresp_data = 32'hDEAD_BEEF;
    tick();
    bus.iresp_valid = 1'b0;
    chk("flush_drop_iv", {63'h0, inst_valid}, 64'h0);
    chk("flush_noreq", {63'h0, bus.ireq_valid}, 64'h0);
    tick();
    chk("flush_iv2", {63'h0, inst_valid}, 64'h0);
    chk("br_req_valid", {63'h0, bus.ireq_valid}, 64'h1);
    chk("br_req_addr", bus.ireq_addr, 64'h8000_1000);

    // Trap and branch together while REQ not accepted: request withdrawn
    trap_valid = 1'b1; trap_target = 64'h8000_0100;
    br_valid = 1'b1;   br_target = 64'h8000_2000;
    tick();
    trap_valid = 1'b0; br_valid = 1'b0;
    chk("wd_noreq", {63'h0, bus.ireq_valid}, 64'h0);
    chk("prio_pc", pc_out, exp_tgt);
    tick();
    do_fetch(exp_tgt, 32'h1111_2222, exp_tgt + 64'h4);

    // Redirect to top of address space; increment wraps to 0
    br_valid = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br_valid = 1'b0;
    chk("br_idle_iv", {63'h0, inst_valid}, 64'h0);
    tick();
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h3333_4444, 64'h0);
    tick();
    chk("wrap_addr", bus.ireq_addr, 64'h0);

    // Async reset in WAIT
    bus.ireq_ready = 1'b1;
    tick();
    bus.ireq_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {63'h0, bus.ireq_valid}, 64'h0);
    chk("arst_req_addr", bus.ireq_addr, RPC);
    chk("arst_pc", pc_out, RPC);
    chk("arst_inst_pc", inst_pc, 64'h0);
    chk("arst_inst_data", {32'h0, inst_data}, 64'h0);
    stall = 1'b1;
    #1 rst_n = 1'b1;
    bus.iresp_valid = 1'b1; bus.iresp_data = 32'h5555_6666;
    tick();
    bus.iresp_valid = 1'b0;
    chk("late_resp_iv", {63'h0, inst_valid}, 64'h0);
    stall = 1'b0;
    tick();
    chk("post_rst_valid", {63'h0, bus.ireq_valid}, 64'h1);
    chk("post_rst_addr", bus.ireq_addr, RPC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end
endmodule
